// File: rtl/spi_adc_scanner_pkg.sv
// rtl/spi_adc_scanner_pkg.sv - shared types and constants for the SPI ADC scanner
package spi_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP
    } state_t;

    localparam int FRAME_OFS  = 6;
    localparam int CH_FIELD_W = 3;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Command word per SCK period: start, SGL, D2, D1, D0, then zeros.
    function automatic logic cmd_bit(input int unsigned period, input logic [CH_FIELD_W-1:0] ch);
        case (period)
            32'd0, 32'd1: return 1'b1;
            32'd2:        return ch[2];
            32'd3:        return ch[1];
            32'd4:        return ch[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_adc_scanner_if.sv
// rtl/spi_adc_scanner_if.sv - SPI pin bundle between scanner (master) and ADC (slave)
interface spi_adc_if;
    logic sck;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sck, output cs, output mosi, input miso);
    modport slave  (input sck, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_adc_scanner_sck_tick_gen.sv
// rtl/spi_adc_scanner_sck_tick_gen.sv - SCK half-period tick every CLK_DIV clk cycles
module sck_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TERM) && !clear;

endmodule

// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - multi-channel SPI ADC scanner (mode 0, MCP320x-style frame)
// Optional 4x averaging per channel with SPI_ADC_AVG_EN.
module spi_adc_scanner
    import spi_adc_pkg::*;
#(
    parameter int  DATA_W  = 12,
    parameter int  N_CH    = 4,
    parameter int  CLK_DIV = 4,
    localparam int CH_W    = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCK,
    output logic              CS,
    output logic [DATA_W-1:0] o_DATA,
    output logic [CH_W-1:0]   o_CH,
    output logic              DATA_VALID,
    output logic              scan_done,
    output logic              busy
);
    localparam int FRAME  = FRAME_OFS + DATA_W;
    localparam int HALF_W = $clog2(2 * FRAME);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * FRAME - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);

    state_t                  state;
    logic                    tick;
    logic                    tick_clear;
    logic                    hold_end;
    logic [HALF_W-1:0]       half_cnt;
    logic [HALF_W-1:0]       next_period;
    logic [CH_W-1:0]         ch_idx;
    logic [CH_FIELD_W-1:0]   ch_field;
    logic [DATA_W-1:0]       shreg;
    logic [DATA_W-1:0]       result;
    logic                    conv_final;
    logic                    scan_end;
    logic                    wrap;

    assign tick_clear  = (state == ST_IDLE);
    assign hold_end    = (state == ST_CS_HOLD) && tick;
    assign ch_field    = CH_FIELD_W'(ch_idx);
    assign next_period = (half_cnt >> 1) + HALF_W'(1);

    // Every phase is a whole number of ticks, so one divider times the lot.
    sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

`ifdef SPI_ADC_AVG_EN
    logic [1:0]        avg_cnt;
    logic [DATA_W+1:0] acc;
    logic [DATA_W+1:0] acc_sum;

    assign acc_sum    = acc + {2'b00, shreg};
    assign conv_final = (avg_cnt == 2'd3);
    assign result     = acc_sum[DATA_W+1:2];

    always_ff @(posedge clk) begin
        if (reset || state == ST_IDLE) begin
            avg_cnt <= '0;
            acc     <= '0;
        end else if (hold_end) begin
            avg_cnt <= avg_cnt + 2'd1;
            acc     <= conv_final ? '0 : acc_sum;
        end
    end
`else
    assign conv_final = 1'b1;
    assign result     = shreg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            CS         <= 1'b1;
            SCK        <= 1'b0;
            MOSI       <= 1'b0;
            o_DATA     <= '0;
            o_CH       <= '0;
            DATA_VALID <= 1'b0;
            scan_done  <= 1'b0;
            busy       <= 1'b0;
            ch_idx     <= '0;
            half_cnt   <= '0;
            shreg      <= '0;
            scan_end   <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            scan_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start || continuous) begin
                        state <= ST_CS_SETUP;
                        CS    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_CS_SETUP: begin
                    if (tick) begin
                        state    <= ST_SHIFT;
                        half_cnt <= '0;
                        MOSI     <= cmd_bit(0, ch_field);
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        SCK <= ~SCK;
                        // Rising half: capture MISO; falling half: present next command bit.
                        if (!SCK) begin
                            shreg <= {shreg[DATA_W-2:0], MISO};
                        end else begin
                            MOSI <= cmd_bit(32'(next_period), ch_field);
                        end
                        if (half_cnt == LAST_HALF) begin
                            state <= ST_CS_HOLD;
                        end else begin
                            half_cnt <= half_cnt + HALF_W'(1);
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (tick) begin
                        state    <= ST_GAP;
                        CS       <= 1'b1;
                        half_cnt <= '0;
                        if (conv_final) begin
                            o_DATA     <= result;
                            o_CH       <= ch_idx;
                            DATA_VALID <= 1'b1;
                            scan_done  <= (ch_idx == LAST_CH);
                            scan_end   <= (ch_idx == LAST_CH);
                            ch_idx     <= (ch_idx == LAST_CH) ? '0 : ch_idx + CH_W'(1);
                        end else begin
                            scan_end <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (scan_done) begin
                        wrap <= continuous;
                    end
                    if (tick) begin
                        if (half_cnt == '0) begin
                            half_cnt <= HALF_W'(1);
                        end else if (scan_end && !wrap) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_CS_SETUP;
                            CS    <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// tb/tb_spi_adc_scanner.sv - directed self-checking bench for spi_adc_scanner
module tb_spi_adc_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0, cont_b = 1'b0;
    logic [11:0] data_a, data_b;
    logic [0:0]  ch_a;
    logic [1:0]  ch_b;
    logic dv_a, dv_b, sd_a, sd_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_fail = 0;

    spi_adc_if bus_a ();
    spi_adc_if bus_b ();

    spi_adc_scanner #(.DATA_W(12), .N_CH(1), .CLK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .continuous(cont_a),
        .MISO(bus_a.miso), .MOSI(bus_a.mosi), .SCK(bus_a.sck), .CS(bus_a.cs),
        .o_DATA(data_a), .o_CH(ch_a), .DATA_VALID(dv_a), .scan_done(sd_a), .busy(busy_a)
    );

    spi_adc_scanner #(.DATA_W(12), .N_CH(4), .CLK_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .continuous(cont_b),
        .MISO(bus_b.miso), .MOSI(bus_b.mosi), .SCK(bus_b.sck), .CS(bus_b.cs),
        .o_DATA(data_b), .o_CH(ch_b), .DATA_VALID(dv_b), .scan_done(sd_b), .busy(busy_b)
    );

    function automatic logic adc_bit(input logic [11:0] v, input int r);
        if (r >= 6 && r < 18) return v[17-r];
        return 1'b0;
    endfunction

    // ADC A: single channel, fixed sample (or 100,101,... when averaging)
    int rises_a = 0;
    int conv_a = 0;
    function automatic logic [11:0] val_a(input int c);
`ifdef SPI_ADC_AVG_EN
        return 12'(100 + c);
`else
        return (c >= 0) ? 12'hA5C : 12'h000;
`endif
    endfunction

    always @(posedge bus_a.sck or negedge bus_a.sck or posedge bus_a.cs) begin
        if (bus_a.cs === 1'b1) begin
            rises_a = 0;
            bus_a.miso = 1'b0;
            if (!reset) conv_a = conv_a + 1;
        end else if (bus_a.sck === 1'b1) begin
            rises_a = rises_a + 1;
        end else begin
            bus_a.miso = adc_bit(val_a(conv_a), rises_a);
        end
    end

    // ADC B: four channels, sample picked by the decoded D1..D0
    logic [11:0] tab_b [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
    int rises_b = 0;
    logic [5:0] cmd_b = 6'd0;
    logic [5:0] frames_b [$];

    always @(posedge bus_b.sck or negedge bus_b.sck or posedge bus_b.cs) begin
        if (bus_b.cs === 1'b1) begin
            frames_b.push_back(cmd_b);
            rises_b = 0;
            cmd_b = 6'd0;
            bus_b.miso = 1'b0;
        end else if (bus_b.sck === 1'b1) begin
            if (rises_b < 6) cmd_b = {cmd_b[4:0], bus_b.mosi};
            rises_b = rises_b + 1;
        end else begin
            bus_b.miso = adc_bit(tab_b[cmd_b[2:1]], rises_b);
        end
    end

    int dv_cnt_a = 0;
    int dv_cnt_b = 0;
    int sd_cnt_b = 0;
    logic [1:0]  ch_q [$];
    logic [11:0] data_q [$];
    logic        sd_q [$];

    always @(negedge clk) begin
        if (dv_a === 1'b1) dv_cnt_a = dv_cnt_a + 1;
        if (sd_b === 1'b1) sd_cnt_b = sd_cnt_b + 1;
        if (dv_b === 1'b1) begin
            dv_cnt_b = dv_cnt_b + 1;
            ch_q.push_back(ch_b);
            data_q.push_back(data_b);
            sd_q.push_back(sd_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] q_ch(input int i);
        return (i < ch_q.size()) ? 32'(ch_q[i]) : 32'bx;
    endfunction
    function automatic logic [31:0] q_data(input int i);
        return (i < data_q.size()) ? 32'(data_q[i]) : 32'bx;
    endfunction
    function automatic logic [31:0] q_sd(input int i);
        return (i < sd_q.size()) ? 32'(sd_q[i]) : 32'bx;
    endfunction
    function automatic logic [31:0] q_frame(input int i);
        return (i < frames_b.size()) ? 32'(frames_b[i]) : 32'bx;
    endfunction

    int base_dv;
    int base_sd;
    int qb;
    int fb;

    initial begin
        wait_n(3);
        reset = 1'b0;
        check("rst_cs", bus_a.cs, 1'b1);
        check("rst_sck", bus_a.sck, 1'b0);
        check("rst_mosi", bus_a.mosi, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_data", data_a, 12'h000);
        check("rst_dv", dv_a, 1'b0);
        check("rst_sd", sd_a, 1'b0);
        check("rst_cs_b", bus_b.cs, 1'b1);
        wait_n(2);
        check("idle_hold_busy", busy_a, 1'b0);

`ifndef SPI_ADC_AVG_EN
        // Single scan on the one-channel scanner, cycle-exact framing
        base_dv = dv_cnt_a;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        check("c1_cs_low", bus_a.cs, 1'b0);
        check("c1_busy", busy_a, 1'b1);
        wait_n(7);
        check("c8_sck_low", bus_a.sck, 1'b0);
        wait_n(1);
        check("c9_sck_high", bus_a.sck, 1'b1);
        wait_n(143);
        check("c152_cs_low", bus_a.cs, 1'b0);
        check("c152_dv", dv_a, 1'b0);
        wait_n(1);
        check("c153_cs_high", bus_a.cs, 1'b1);
        check("c153_dv", dv_a, 1'b1);
        check("c153_sd", sd_a, 1'b1);
        check("c153_data", data_a, 12'hA5C);
        check("c153_ch", ch_a, 1'b0);
        wait_n(1);
        check("c154_dv", dv_a, 1'b0);
        check("c154_data_hold", data_a, 12'hA5C);
        wait_n(6);
        check("c160_busy", busy_a, 1'b1);
        wait_n(1);
        check("c161_busy", busy_a, 1'b0);
        check("a_dv_count", dv_cnt_a - base_dv, 1);

        // Four-channel single scan; a start pulse mid-frame must be ignored
        base_dv = dv_cnt_b;
        base_sd = sd_cnt_b;
        qb = ch_q.size();
        fb = frames_b.size();
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        wait_n(19);
        start_b = 1'b1;
        wait_n(1);
        start_b = 1'b0;
        for (int k = 0; k < 1000 && busy_b; k++) @(negedge clk);
        check("scan_idle", busy_b, 1'b0);
        check("scan_dv_count", dv_cnt_b - base_dv, 4);
        check("scan_sd_count", sd_cnt_b - base_sd, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("scan_ch%0d", i), q_ch(qb + i), 32'(i));
            check($sformatf("scan_data%0d", i), q_data(qb + i), 32'(tab_b[i]));
            check($sformatf("scan_sd%0d", i), q_sd(qb + i), (i == 3) ? 32'd1 : 32'd0);
        end
        check("mosi_ch0", q_frame(fb), 32'b110000);
        check("mosi_ch2", q_frame(fb + 2), 32'b110100);
        check("mosi_ch3", q_frame(fb + 3), 32'b110110);
        wait_n(20);
        check("start_not_queued", busy_b, 1'b0);

        // Continuous scanning wraps to channel 0 until continuous drops
        qb = ch_q.size();
        cont_b = 1'b1;
        for (int k = 0; k < 1500 && (ch_q.size() - qb) < 6; k++) @(negedge clk);
        cont_b = 1'b0;
        check("cont_reached_six", (ch_q.size() - qb) >= 6, 1'b1);
        for (int k = 0; k < 1000 && busy_b; k++) @(negedge clk);
        check("cont_idle", busy_b, 1'b0);
        check("cont_count", ch_q.size() - qb, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("cont_ch%0d", i), q_ch(qb + i), 32'(i % 4));
            check($sformatf("cont_sd%0d", i), q_sd(qb + i), ((i % 4) == 3) ? 32'd1 : 32'd0);
        end

        // Reset during a frame at cycle 60 (SCK high there)
        base_dv = dv_cnt_b;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        wait_n(59);
        check("c60_sck_high", bus_b.sck, 1'b1);
        reset = 1'b1;
        wait_n(1);
        reset = 1'b0;
        check("mid_rst_cs", bus_b.cs, 1'b1);
        check("mid_rst_sck", bus_b.sck, 1'b0);
        check("mid_rst_busy", busy_b, 1'b0);
        check("mid_rst_mosi", bus_b.mosi, 1'b0);
        check("mid_rst_data", data_b, 12'h000);
        check("mid_rst_ch", ch_b, 2'd0);
        wait_n(300);
        check("mid_rst_no_dv", dv_cnt_b - base_dv, 0);
        check("mid_rst_stays_idle", busy_b, 1'b0);
`else
        // Four conversions of 100..103 average to 101 with one strobe
        base_dv = dv_cnt_a;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 800 && dv_a !== 1'b1; k++) @(negedge clk);
        check("avg_dv", dv_a, 1'b1);
        check("avg_data", data_a, 12'd101);
        check("avg_ch", ch_a, 1'b0);
        check("avg_sd", sd_a, 1'b1);
        for (int k = 0; k < 200 && busy_a; k++) @(negedge clk);
        check("avg_idle", busy_a, 1'b0);
        check("avg_dv_count", dv_cnt_a - base_dv, 1);
        check("avg_conv_count", conv_a, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
